// File: rtl/imu_filter_pkg.sv
// Shared constants, FIR coefficients and FSM encoding for the IMU filter sequencer.
package imu_filter_pkg;
  localparam int TAPS_D      = 10;
  localparam int DATA_W_D    = 10;
  localparam int COEF_W_D    = 16;
  localparam int OUT_SHIFT_D = 18;

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  // Symmetric low-pass taps; index out of range reads as zero.
  function automatic logic [15:0] coef(input logic [3:0] i);
    case (i)
      4'd0, 4'd9: coef = 16'h55a9;
      4'd1, 4'd8: coef = 16'h4995;
      4'd2, 4'd7: coef = 16'h5eb7;
      4'd3, 4'd6: coef = 16'h6efd;
      4'd4, 4'd5: coef = 16'h77ca;
      default:    coef = 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/imu_sample_history.sv
// Three-axis TAPS-deep sample history with shift enable and an axis/tap read mux.
module imu_sample_history #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 10,
  parameter int TAP_W  = 4
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   shift_en,
  input  logic [2:0][DATA_W-1:0] din,
  input  logic [1:0]             axis,
  input  logic [TAP_W-1:0]       tap,
  output logic [DATA_W-1:0]      dout
);
  localparam logic [TAP_W-1:0] LAST = TAP_W'(TAPS - 1);

  logic [2:0][TAPS-1:0][DATA_W-1:0] hist;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) hist <= '0;
    else if (shift_en)
      for (int a = 0; a < 3; a++) hist[a] <= {hist[a][TAPS-2:0], din[a]};
  end

  assign dout = (axis <= 2'd2 && tap <= LAST) ? hist[axis][tap] : '0;
endmodule

// File: rtl/imu_filter_sequencer.sv
// Time-multiplexed 3-axis FIR: one shared MAC walks every tap of X, Y, Z, then publishes all three.
module imu_filter_sequencer import imu_filter_pkg::*; #(
  parameter int TAPS      = TAPS_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int COEF_W    = COEF_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              SampleValid,
  input  logic [DATA_W-1:0] AccelX,
  input  logic [DATA_W-1:0] AccelY,
  input  logic [DATA_W-1:0] AccelZ,
  input  logic              ClearOverrun,
  output logic              SampleReady,
  output logic [DATA_W-1:0] AccelXOut,
  output logic [DATA_W-1:0] AccelYOut,
  output logic [DATA_W-1:0] AccelZOut,
  output logic              DataReady,
  output logic              Overrun
);
  localparam int TAP_W = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam logic [TAP_W-1:0] LAST    = TAP_W'(TAPS - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  state_t                   state, state_nxt;
  logic                     shift_en;
  logic [1:0]               axis;
  logic [TAP_W-1:0]         tap;
  logic [ACC_W-1:0]         acc, prod, shifted;
  logic [COEF_W-1:0]        coef_val;
  logic [DATA_W-1:0]        h_val, sat_val;
  logic [1:0][DATA_W-1:0]   staged;
  logic [2:0][DATA_W-1:0]   din;

  assign din = {AccelZ, AccelY, AccelX};

  imu_sample_history #(.TAPS(TAPS), .DATA_W(DATA_W), .TAP_W(TAP_W)) u_hist (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .shift_en(shift_en),
    .din     (din),
    .axis    (axis),
    .tap     (tap),
    .dout    (h_val)
  );

  assign coef_val = COEF_W'(coef(4'(tap)));
  assign prod     = ACC_W'(coef_val) * ACC_W'(h_val);
  assign shifted  = acc >> OUT_SHIFT;
  assign sat_val  = (shifted > SAT_MAX) ? DATA_W'(SAT_MAX) : shifted[DATA_W-1:0];
  assign SampleReady = (state == IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    case (state)
      IDLE:  if (SampleValid) begin
               shift_en  = 1'b1;
               state_nxt = MAC;
             end
      MAC:   if (tap == LAST) state_nxt = WRITE;
      WRITE: state_nxt = (axis == 2'd2) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      axis      <= '0;
      tap       <= '0;
      acc       <= '0;
      staged    <= '0;
      AccelXOut <= '0;
      AccelYOut <= '0;
      AccelZOut <= '0;
      DataReady <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      DataReady <= 1'b0;
      case (state)
        IDLE: if (SampleValid) begin
          axis <= '0;
          tap  <= '0;
        end
        MAC: begin
          acc <= ((tap == '0) ? '0 : acc) + prod;
          tap <= (tap == LAST) ? '0 : tap + 1'b1;
        end
        WRITE: begin
          // Z completes the set: all three outputs move together with the pulse.
          if (axis == 2'd2) begin
            AccelXOut <= staged[0];
            AccelYOut <= staged[1];
            AccelZOut <= sat_val;
            DataReady <= 1'b1;
          end else begin
            staged[axis[0]] <= sat_val;
            axis            <= axis + 2'd1;
          end
        end
        default: ;
      endcase
      if (SampleValid && state != IDLE) Overrun <= 1'b1;
      else if (ClearOverrun)            Overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imu_filter_sequencer.sv
// Randomized scoreboard bench: reference FIR model predicts each result and its cycle.
module tb_imu_filter_sequencer;
  logic       Clock = 0, Reset_n = 0, SampleValid = 0, ClearOverrun = 0;
  logic [9:0] AccelX = 0, AccelY = 0, AccelZ = 0;
  logic       rdy1, rdy2, dr1, dr2, ov1, ov2;
  logic [9:0] x1, y1, z1, x2, y2, z2;

  imu_filter_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .SampleValid(SampleValid),
    .AccelX(AccelX), .AccelY(AccelY), .AccelZ(AccelZ), .ClearOverrun(ClearOverrun),
    .SampleReady(rdy1), .AccelXOut(x1), .AccelYOut(y1), .AccelZOut(z1),
    .DataReady(dr1), .Overrun(ov1));

  imu_filter_sequencer #(.OUT_SHIFT(16)) dut_s16 (
    .Clock(Clock), .Reset_n(Reset_n), .SampleValid(SampleValid),
    .AccelX(AccelX), .AccelY(AccelY), .AccelZ(AccelZ), .ClearOverrun(ClearOverrun),
    .SampleReady(rdy2), .AccelXOut(x2), .AccelYOut(y2), .AccelZOut(z2),
    .DataReady(dr2), .Overrun(ov2));

  always #5 Clock = ~Clock;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain history arrays and arithmetic.
  typedef struct packed { int due; logic [2:0][9:0] v; logic [2:0][9:0] s; } exp_t;
  int         CO[10] = '{21929, 18837, 24247, 28413, 30666, 30666, 28413, 24247, 18837, 21929};
  int         hist[3][10];
  exp_t       q[$];
  int         cyc, busy;
  bit         m_ov;
  logic [2:0][9:0] held, held2;

  function automatic int filt(input int a, input int sh);
    longint s = 0;
    for (int k = 0; k < 10; k++) s += longint'(CO[k]) * longint'(hist[a][k]);
    s = s >> sh;
    return (s > 1023) ? 1023 : int'(s);
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc = 0; busy = 0; m_ov = 0; held = '0; held2 = '0;
      q.delete();
      for (int a = 0; a < 3; a++) for (int k = 0; k < 10; k++) hist[a][k] = 0;
    end else begin
      exp_t e;
      bit   rdy;
      cyc++;
      rdy = (busy == 0);
      if (SampleValid && !rdy) m_ov = 1;
      else if (ClearOverrun)   m_ov = 0;
      if (rdy && SampleValid) begin
        int in[3];
        in[0] = AccelX; in[1] = AccelY; in[2] = AccelZ;
        for (int a = 0; a < 3; a++) begin
          for (int k = 9; k > 0; k--) hist[a][k] = hist[a][k-1];
          hist[a][0] = in[a];
        end
        e.due = cyc + 33;
        for (int a = 0; a < 3; a++) begin
          e.v[a] = 10'(filt(a, 18));
          e.s[a] = 10'(filt(a, 16));
        end
        q.push_back(e);
        busy = 33;
      end else if (busy > 0) busy--;
    end
  end

  // Monitor: DataReady timing, output values/holding, ready and overrun flags.
  always @(negedge Clock) begin
    if (Reset_n) begin
      bit exp_dr;
      exp_dr = (q.size() > 0) && (q[0].due == cyc);
      chk("data_ready", dr1, exp_dr);
      chk("data_ready_s16", dr2, exp_dr);
      if (exp_dr) begin
        exp_t e;
        e = q.pop_front();
        held = e.v; held2 = e.s;
      end
      chk("out_x", x1, held[0]);  chk("out_y", y1, held[1]);  chk("out_z", z1, held[2]);
      chk("s16_x", x2, held2[0]); chk("s16_y", y2, held2[1]); chk("s16_z", z2, held2[2]);
      chk("sample_ready", rdy1, busy == 0);
      chk("overrun", ov1, m_ov);
      chk("overrun_s16", ov2, m_ov);
    end
  end

  task automatic step();
    @(negedge Clock); #1;
  endtask

  // One accept, 33 further cycles; an optional extra strobe lands on edge ov_at.
  task automatic send(input int x, input int y, input int z, input int ov_at = -1, input bit ov_clr = 0);
    step();
    SampleValid = 1; AccelX = 10'(x); AccelY = 10'(y); AccelZ = 10'(z);
    for (int e = 1; e <= 33; e++) begin
      step();
      SampleValid  = (e == ov_at);
      ClearOverrun = (e == ov_at) && ov_clr;
      if (e == ov_at) begin
        AccelX = 10'($urandom); AccelY = 10'($urandom); AccelZ = 10'($urandom);
      end
    end
    SampleValid = 0; ClearOverrun = 0;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    chk("rst_x", x1, 0); chk("rst_y", y1, 0); chk("rst_z", z1, 0);
    chk("rst_dr", dr1, 0); chk("rst_ready", rdy1, 1); chk("rst_ov", ov1, 0);
    #1 Reset_n = 1;
    repeat (100) step();

    send(1023, 1023, 1023); step();
    chk("impulse_x", x1, 85); chk("impulse_y", y1, 85); chk("impulse_z", z1, 85);
    send(0, 0, 0); step();
    chk("impulse_tail_x", x1, 73); chk("impulse_tail_z", z1, 73);

    repeat (10) send(1023, 512, 0); step();
    chk("step_x", x1, 968); chk("step_y", y1, 484); chk("step_z", z1, 0);

    send(1023, 512, 0, 5); step();
    chk("overrun_set", ov1, 1);
    chk("overrun_same_result_x", x1, 968); chk("overrun_same_result_y", y1, 484);
    ClearOverrun = 1; step(); ClearOverrun = 0; step();
    chk("overrun_cleared", ov1, 0);
    send(300, 600, 900, 7, 1); step();
    chk("overrun_set_wins", ov1, 1);

    step(); SampleValid = 1; AccelX = 1023; AccelY = 1023; AccelZ = 1023;
    step(); SampleValid = 0;
    repeat (14) step();
    Reset_n = 0; step();
    chk("abort_x", x1, 0); chk("abort_z", z1, 0); chk("abort_dr", dr1, 0);
    step(); Reset_n = 1;
    repeat (40) step();
    send(1023, 1023, 1023); step();
    chk("post_abort_impulse_x", x1, 85); chk("post_abort_impulse_y", y1, 85);

    repeat (10) send(1023, 1023, 1023); step();
    chk("sat_x", x2, 1023); chk("sat_y", y2, 1023); chk("sat_z", z2, 1023);

    for (int i = 0; i < 2000; i++) begin
      step();
      SampleValid  = ($urandom_range(0, 7) == 0);
      ClearOverrun = ($urandom_range(0, 15) == 0);
      AccelX = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom);
      AccelY = 10'($urandom);
      AccelZ = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
    end
    SampleValid = 0; ClearOverrun = 0;
    repeat (40) step();
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
